// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the instruction/data SRAM bus arbiter: access sizes,
// FSM states and grant identifiers.
package sram_bus_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// port that did not win last time is chosen.
module rr_arbiter2
  import sram_bus_arbiter_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       last_grant,
  output logic       any,
  output logic       grant
);

  always_comb begin
    any = inst_req | data_req;
    if (inst_req && data_req) grant = ~last_grant;
    else if (data_req)        grant = GNT_DATA;
    else                      grant = GNT_INST;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like master port between the instruction-fetch and data
// ports, one outstanding transaction at a time, round-robin on contention.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_uncached,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              data_uncached,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_uncached,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   pick_any;
  logic   pick;

  rr_arbiter2 u_rr (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant),
    .any        (pick_any),
    .grant      (pick)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GNT_INST;
      last_grant <= GNT_DATA;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          state <= ADDR;
          grant <= pick;
        end
        ADDR: if (m_addr_ok) begin
          state      <= RESP;
          last_grant <= grant;
        end
        RESP: if (m_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so nothing leaks while reset is being applied
  // mid-transaction; stray m_data_ok outside RESP never reaches a port.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_addr       = '0;
    m_wdata      = '0;
    m_uncached   = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = rst ? '0 : m_rdata;
    data_rdata   = rst ? '0 : m_rdata;
    if (!rst) begin
      case (state)
        ADDR: begin
          m_req = 1'b1;
          if (grant == GNT_DATA) begin
            m_wr         = data_wr;
            m_size       = data_size;
            m_addr       = data_addr;
            m_wdata      = data_wdata;
            m_uncached   = data_uncached;
            data_addr_ok = m_addr_ok;
          end else begin
            m_size       = SIZE_WORD;
            m_addr       = inst_addr;
            m_uncached   = inst_uncached;
            inst_addr_ok = m_addr_ok;
          end
        end
        RESP: begin
          if (grant == GNT_DATA) data_data_ok = m_data_ok;
          else                   inst_data_ok = m_data_ok;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like master port between the instruction-fetch port and the data-access port of the CPU core.
- Sits after address translation. All addresses presented here are already physical, and the uncached attribute comes from the translation stage.
- Allows one outstanding transaction at a time.
- Uses round-robin arbitration so that neither port starves the other. The cache/bridge layer behind the master port sees a single requester.

Parameters:
- ADDR_W, 32, physical address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction request; held with fields stable until inst_addr_ok.
- inst_addr  in  ADDR_W  instruction physical address.
- inst_uncached  in  1  instruction access bypasses cache.
- inst_addr_ok  out  1  instruction address accepted.
- inst_data_ok  out  1  instruction read data valid.
- inst_rdata  out  DATA_W  instruction read data.
- data_req  in  1  data request; held with fields stable until data_addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  data physical address.
- data_wdata  in  DATA_W  write data.
- data_uncached  in  1  data access bypasses cache.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  data response (read data or write done).
- data_rdata  out  DATA_W  data read data.
- m_req  out  1  master request.
- m_wr  out  1  master write.
- m_size  out  2  master size.
- m_addr  out  ADDR_W  master address.
- m_wdata  out  DATA_W  master write data.
- m_uncached  out  1  master uncached attribute.
- m_addr_ok  in  1  master address accepted.
- m_data_ok  in  1  master response valid.
- m_rdata  in  DATA_W  master read data.

Behaviour:
- State machine states: IDLE, ADDR, RESP. Registers: state, grant (0 = inst, 1 = data), last_grant.
- IDLE:
  - m_req = 0.
  - If any request is present, go to ADDR next cycle with grant chosen as follows.
  - Only one request present: grant that port.
  - Both present: grant the port not equal to last_grant.
  - Minimum latency from req to m_req is 1 cycle.
- ADDR:
  - m_req = 1. m_wr, m_size, m_addr, m_wdata and m_uncached are driven combinationally from the granted port.
  - Instruction grant forces m_wr = 0 and m_size = 2; m_wdata is don't-care.
  - The granted port's addr_ok = m_addr_ok. The other port's addr_ok = 0.
  - On m_addr_ok: go to RESP and set last_grant <= grant.
- RESP:
  - m_req = 0.
  - The granted port's data_ok = m_data_ok, and its rdata = m_rdata. The other port's data_ok = 0.
  - On m_data_ok: go to IDLE. The next request costs one idle bubble; back-to-back throughput is 1 transaction per (3 + slave latency) cycles.
- m_data_ok in IDLE or ADDR is ignored and never forwarded. The slave guarantees data_ok at least one cycle after addr_ok.
- The non-granted request stays pending; its requester keeps req high and is served next.
- When neither port is granted, inst_rdata and data_rdata may carry m_rdata. Only the data_ok strobes qualify them.
- Reset values:
  - state = IDLE, grant = 0, last_grant = 1 (instruction wins the first tie).
  - m_req = 0 and all addr_ok/data_ok outputs = 0.
  - m_wr, m_size, m_addr, m_wdata and m_uncached = 0 while in IDLE.
- Reset mid-transaction: on rst, return to IDLE immediately and drop the outstanding transaction. A late m_data_ok after reset is ignored as in IDLE.
- A requester dropping req while in ADDR is a protocol violation and is not handled.

Decomposition:
- Shared package: size encodings SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2; state encodings IDLE/ADDR/RESP; grant encodings GNT_INST = 0, GNT_DATA = 1.
- One natural sub-module: rr_arbiter2, a 2-input round-robin pick from two request bits and last_grant. The FSM, muxing and response steering stay in the top module.

Test Plan:
- Single inst read: inst_req = 1 with addr 0x1FC0_0000, no data_req; slave gives addr_ok on cycle 2 and data_ok on cycle 4 with rdata 0x3C08_BFAF → m_req high on cycle 1 only after req, m_addr = 0x1FC0_0000, m_wr = 0, m_size = 2; inst_addr_ok on cycle 2; inst_data_ok on cycle 4 with 0x3C08_BFAF; data_* strobes stay 0.
- Data byte write, uncached: data_req, wr = 1, size = 0, addr 0x1FAF_F000, wdata 0xAB, uncached = 1 → m_wr = 1, m_size = 0, m_uncached = 1, m_wdata = 0xAB; data_data_ok when m_data_ok arrives; data_rdata is not checked.
- Simultaneous requests from reset: inst 0x0000_1000 and data 0x0000_2000 both asserted → inst served first (last_grant reset = 1); data served next, after inst_data_ok plus one IDLE cycle.
- Continuous contention for 8 transactions → grants alternate inst/data/inst/…; each port gets exactly 4 grants.
- Stray response: m_data_ok pulsed while in IDLE, and again in ADDR before m_addr_ok → no inst_data_ok or data_data_ok emitted; state unchanged.
- Reset mid-operation: rst asserted in RESP, then m_data_ok arrives one cycle after rst deasserts → all outputs 0 during reset; response not forwarded; a new inst_req is granted normally afterwards.
